sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Single-port SRAM arbiter between the frame-write path (Write_Controller) and the rotated-read path (Read_Controller). It replaces the bare enable/address mux in front of SRAM_Model with a request/grant handshake, bounded-burst round-robin arbitration, registered SRAM pins and read-data-valid tracking. Overlapping capture and readout can then share one SRAM without collisions.

## Interface
- AW, 20, SRAM address width
- DW, 24, pixel/data width (RGB888)
- MAX_BURST, 16, max consecutive grants to one owner while the other side is requesting; legal range 1..255
- Clk_in  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- wr_req  in  1  write request; held with wr_addr/wr_data until granted
- wr_addr  in  AW  write address
- wr_data  in  DW  write data
- wr_gnt  out  1  combinational; write accepted at this edge when wr_req&wr_gnt
- rd_req  in  1  read request; held with rd_addr until granted
- rd_addr  in  AW  read address
- rd_gnt  out  1  combinational; read accepted at this edge when rd_req&rd_gnt
- rd_dvalid  out  1  registered; rd_rdata valid this cycle
- rd_rdata  out  DW  equals sram_dout, meaningful only with rd_dvalid
- sram_en  out  1  registered SRAM enable
- sram_we  out  1  registered SRAM write enable
- sram_addr  out  AW  registered SRAM address
- sram_din  out  DW  registered SRAM write data
- sram_dout  in  DW  SRAM read data, valid one cycle after the sampling edge
- conflict_cnt  out  16  present only with SRAM_ARB_STATS_EN

## Operation
- States: IDLE, WR_OWN, RD_OWN. burst_cnt is an 8-bit counter of consecutive grants to the current owner.
- IDLE:
  - Write only requests: grant write, go to WR_OWN, burst_cnt=1.
  - Read only requests: grant read, go to RD_OWN, burst_cnt=1.
  - Both request: write wins, so capture is never stalled from idle.
  - Neither requests: stay in IDLE.
- WR_OWN / RD_OWN, per cycle:
  - Owner requests, other side idle: grant owner; burst_cnt saturates at MAX_BURST.
  - Both request and burst_cnt < MAX_BURST: grant owner, burst_cnt+1.
  - Both request and burst_cnt ≥ MAX_BURST: grant the other side, switch state, burst_cnt=1.
  - Only the other side requests: grant it, switch state, burst_cnt=1.
  - Neither requests: go to IDLE, burst_cnt=0.
- At most one grant per cycle. wr_gnt and rd_gnt are never high together.
- An accepted request is registered onto the sram_* pins at the accepting edge:
  - Write: en=1, we=1, addr, din.
  - Read: en=1, we=0, addr; din holds its previous value.
  - No accept: en=0, we=0; addr and din hold.
- Accesses reach the SRAM in acceptance order, so a read accepted after a write to the same address returns the new data.
- Reset mid-operation:
  - State → IDLE, burst_cnt=0, pipeline cleared.
  - A read accepted before reset never produces rd_dvalid.
  - Grants are 0 while Reset=1.

## Timing
- Reset values: wr_gnt=0, rd_gnt=0, rd_dvalid=0, sram_en=0, sram_we=0, sram_addr=0, sram_din=0, conflict_cnt=0.
- Read accepted at edge E:
  - sram_en/addr driven after E.
  - SRAM samples at E+1.
  - rd_dvalid high from E+1 to E+2.
  - Requester captures rd_rdata at E+2, i.e. 2-cycle read latency.
- Write accepted at edge E: SRAM stores at E+1.
- Throughput: one access per cycle. Back-to-back reads give a rd_dvalid every cycle.
- Requester rule: req, addr and data must stay stable until the edge where gnt=1. Dropping req before grant is allowed and loses nothing.

## Configuration
- SRAM_ARB_STATS_EN defined:
  - conflict_cnt port exists.
  - It increments every cycle wr_req&rd_req=1 (Reset=0), saturates at 16'hFFFF, and clears on Reset.
- SRAM_ARB_STATS_EN undefined: port and counter are absent; arbitration behaviour is identical.

## Test plan
- Reset: hold Reset=1 for 3 cycles with both reqs high → all grants and sram_* outputs 0, no rd_dvalid. First cycle after release → wr_gnt=1.
- Lone read: rd_req with rd_addr=20'h00010 against preloaded 24'hA1B2C3 → rd_gnt at E; rd_dvalid=1 with rd_rdata=24'hA1B2C3 at E+2, then rd_dvalid=0.
- Contention, MAX_BURST=4, both reqs held 12 cycles → grant pattern W×4, R×4, W×4; wr_gnt&rd_gnt never both 1.
- Write-then-read same address 20'h0FFFF, data 24'h123456, requests issued consecutively → read returns 24'h123456.
- Reset asserted one cycle after a read accept → no rd_dvalid ever appears; state is IDLE after release.
- With SRAM_ARB_STATS_EN, 10 contention cycles → conflict_cnt=10. Forced 70000 contention cycles → conflict_cnt=16'hFFFF.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter: write/read request-grant, bounded-burst round robin,
// registered SRAM pins and read-data-valid tracking. Optional SRAM_ARB_STATS_EN adds conflict_cnt.
module sram_port_arbiter #(
  parameter int unsigned AW        = 20,
  parameter int unsigned DW        = 24,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic          Clk_in,
  input  logic          Reset,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_gnt,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_gnt,
  output logic          rd_dvalid,
  output logic [DW-1:0] rd_rdata,
  output logic          sram_en,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]   conflict_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, WR_OWN, RD_OWN} state_t;

  localparam logic [7:0] MAXB = 8'(MAX_BURST);

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_burst, w_burst_nxt, w_burst_inc;
  logic          w_wr_gnt, w_rd_gnt;
  logic          r_rd_issued, r_rd_dvalid;
  logic          r_sram_en, r_sram_we;
  logic [AW-1:0] r_sram_addr;
  logic [DW-1:0] r_sram_din;

  always_comb begin
    w_wr_gnt    = 1'b0;
    w_rd_gnt    = 1'b0;
    w_state_nxt = r_state;
    w_burst_nxt = r_burst;
    w_burst_inc = (r_burst >= MAXB) ? MAXB : r_burst + 8'd1;
    case (r_state)
      IDLE: begin
        if (wr_req) begin
          w_wr_gnt    = 1'b1;
          w_state_nxt = WR_OWN;
          w_burst_nxt = 8'd1;
        end else if (rd_req) begin
          w_rd_gnt    = 1'b1;
          w_state_nxt = RD_OWN;
          w_burst_nxt = 8'd1;
        end else begin
          w_burst_nxt = '0;
        end
      end
      // Owner keeps the port unless the other side waits and the burst is used up.
      WR_OWN: begin
        if (wr_req && (!rd_req || (r_burst < MAXB))) begin
          w_wr_gnt    = 1'b1;
          w_burst_nxt = w_burst_inc;
        end else if (rd_req) begin
          w_rd_gnt    = 1'b1;
          w_state_nxt = RD_OWN;
          w_burst_nxt = 8'd1;
        end else begin
          w_state_nxt = IDLE;
          w_burst_nxt = '0;
        end
      end
      RD_OWN: begin
        if (rd_req && (!wr_req || (r_burst < MAXB))) begin
          w_rd_gnt    = 1'b1;
          w_burst_nxt = w_burst_inc;
        end else if (wr_req) begin
          w_wr_gnt    = 1'b1;
          w_state_nxt = WR_OWN;
          w_burst_nxt = 8'd1;
        end else begin
          w_state_nxt = IDLE;
          w_burst_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_burst_nxt = '0;
      end
    endcase
    if (Reset) begin
      w_wr_gnt    = 1'b0;
      w_rd_gnt    = 1'b0;
      w_state_nxt = IDLE;
      w_burst_nxt = '0;
    end
  end

  always_ff @(posedge Clk_in) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_burst     <= '0;
      r_sram_en   <= 1'b0;
      r_sram_we   <= 1'b0;
      r_sram_addr <= '0;
      r_sram_din  <= '0;
      r_rd_issued <= 1'b0;
      r_rd_dvalid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst     <= w_burst_nxt;
      r_rd_issued <= w_rd_gnt;
      r_rd_dvalid <= r_rd_issued;
      if (w_wr_gnt) begin
        r_sram_en   <= 1'b1;
        r_sram_we   <= 1'b1;
        r_sram_addr <= wr_addr;
        r_sram_din  <= wr_data;
      end else if (w_rd_gnt) begin
        r_sram_en   <= 1'b1;
        r_sram_we   <= 1'b0;
        r_sram_addr <= rd_addr;
      end else begin
        r_sram_en   <= 1'b0;
        r_sram_we   <= 1'b0;
      end
    end
  end

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] r_conflict;

  always_ff @(posedge Clk_in) begin
    if (Reset) begin
      r_conflict <= '0;
    end else if (wr_req && rd_req && (r_conflict != '1)) begin
      r_conflict <= r_conflict + 16'd1;
    end
  end

  assign conflict_cnt = r_conflict;
`endif

  assign wr_gnt    = w_wr_gnt;
  assign rd_gnt    = w_rd_gnt;
  assign rd_dvalid = r_rd_dvalid;
  assign rd_rdata  = sram_dout;
  assign sram_en   = r_sram_en;
  assign sram_we   = r_sram_we;
  assign sram_addr = r_sram_addr;
  assign sram_din  = r_sram_din;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: vector table, directed corner sequences and
// random traffic against a run-length arbitration model and an SRAM model.
module tb_sram_port_arbiter;
  localparam int AW = 20;
  localparam int DW = 24;
  localparam int MB = 4;

  logic          Clk_in = 1'b0;
  logic          Reset = 1'b1;
  logic          wr_req = 1'b0, rd_req = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_gnt, rd_gnt, rd_dvalid;
  logic [DW-1:0] rd_rdata;
  logic          sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout = '0;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0]   conflict_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 Clk_in = ~Clk_in;

  sram_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .Clk_in(Clk_in), .Reset(Reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_dvalid(rd_dvalid), .rd_rdata(rd_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
`ifdef SRAM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  // SRAM: samples its pins on the rising edge, read data appears after that edge
  logic [DW-1:0] sram_mem [logic [AW-1:0]];
  always @(posedge Clk_in) begin
    if (sram_en) begin
      if (sram_we) sram_mem[sram_addr] = sram_din;
      else sram_dout <= sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : '0;
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int            m_owner;   // 0 none, 1 write, 2 read
  int            m_streak;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic          m_iss, m_dv;
  logic [DW-1:0] m_iss_data, m_dv_data;
`ifdef SRAM_ARB_STATS_EN
  int            m_conf;
`endif

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic w, input logic r,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] ra, output logic gw, output logic gr);
    int side;
    Reset = rst; wr_req = w; rd_req = r;
    wr_addr = wa; wr_data = wd; rd_addr = ra;
    #1;
    side = 0;
    if (!rst) begin
      if (w && r) side = (m_owner == 0) ? 1 : ((m_streak < MB) ? m_owner : 3 - m_owner);
      else if (w) side = 1;
      else if (r) side = 2;
    end
    chk("wr_gnt", 32'(wr_gnt), 32'(side == 1));
    chk("rd_gnt", 32'(rd_gnt), 32'(side == 2));
    chk("gnt_exclusive", 32'(wr_gnt & rd_gnt), 32'd0);
    gw = wr_gnt; gr = rd_gnt;
    if (rst) begin
      m_owner = 0; m_streak = 0;
      m_en = 0; m_we = 0; m_addr = '0; m_din = '0;
      m_iss = 0; m_dv = 0;
`ifdef SRAM_ARB_STATS_EN
      m_conf = 0;
`endif
    end else begin
`ifdef SRAM_ARB_STATS_EN
      if (w && r && m_conf < 65535) m_conf++;
`endif
      if (side == 0) begin
        m_owner = 0; m_streak = 0;
      end else if (side == m_owner) begin
        m_streak = (m_streak + 1 > MB) ? MB : m_streak + 1;
      end else begin
        m_owner = side; m_streak = 1;
      end
      m_dv = m_iss; m_dv_data = m_iss_data;
      m_iss = (side == 2);
      if (side == 1) begin
        m_en = 1; m_we = 1; m_addr = wa; m_din = wd; ref_mem[wa] = wd;
      end else if (side == 2) begin
        m_en = 1; m_we = 0; m_addr = ra; m_iss_data = ref_rd(ra);
      end else begin
        m_en = 0; m_we = 0;
      end
    end
    @(posedge Clk_in); #1;
    chk("sram_en", 32'(sram_en), 32'(m_en));
    chk("sram_we", 32'(sram_we), 32'(m_we));
    chk("sram_addr", 32'(sram_addr), 32'(m_addr));
    chk("sram_din", 32'(sram_din), 32'(m_din));
    chk("rd_dvalid", 32'(rd_dvalid), 32'(m_dv));
    if (m_dv) chk("rd_rdata", 32'(rd_rdata), 32'(m_dv_data));
`ifdef SRAM_ARB_STATS_EN
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
`endif
  endtask

  task automatic idle_cyc(input logic rst);
    logic gw, gr;
    cycle(rst, 1'b0, 1'b0, '0, '0, '0, gw, gr);
  endtask

  typedef struct {
    logic w, r, ew, er;
  } vec_t;
  vec_t tbl [21];

  initial begin
    logic gw, gr;
    logic pw, pr;
    logic [AW-1:0] pwa, pra;
    logic [DW-1:0] pwd;

    for (int i = 0; i < 12; i++) tbl[i] = '{1'b1, 1'b1, ((i / 4) % 2) == 0, ((i / 4) % 2) == 1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[20] = '{1'b1, 1'b0, 1'b1, 1'b0};

    // Reset held 3 cycles with both requests high, then write wins from idle
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 20'h1, 24'h1, 20'h2, gw, gr);
    cycle(1'b0, 1'b1, 1'b1, 20'h1, 24'h1, 20'h2, gw, gr);
    chk("first_after_reset_wr_gnt", 32'(gw), 32'd1);
    idle_cyc(1'b1);

    // Grant pattern table from idle
    for (int i = 0; i < 21; i++) begin
      cycle(1'b0, tbl[i].w, tbl[i].r, AW'(i + 32), DW'(24'h5A0000 + i), AW'(i + 32), gw, gr);
      chk("tbl_wr_gnt", 32'(gw), 32'(tbl[i].ew));
      chk("tbl_rd_gnt", 32'(gr), 32'(tbl[i].er));
    end
    idle_cyc(1'b0);
    idle_cyc(1'b0);

    // Lone read of a preloaded word: two-cycle latency, single dvalid
    sram_mem[20'h00010] = 24'hA1B2C3;
    ref_mem[20'h00010]  = 24'hA1B2C3;
    cycle(1'b0, 1'b0, 1'b1, '0, '0, 20'h00010, gw, gr);
    chk("lone_rd_gnt", 32'(gr), 32'd1);
    chk("lone_dvalid_e1", 32'(rd_dvalid), 32'd0);
    idle_cyc(1'b0);
    chk("lone_dvalid_e2", 32'(rd_dvalid), 32'd1);
    chk("lone_rdata", 32'(rd_rdata), 32'h00A1B2C3);
    idle_cyc(1'b0);
    chk("lone_dvalid_after", 32'(rd_dvalid), 32'd0);

    // Write then read of the same address in consecutive cycles
    cycle(1'b0, 1'b1, 1'b0, 20'h0FFFF, 24'h123456, '0, gw, gr);
    cycle(1'b0, 1'b0, 1'b1, '0, '0, 20'h0FFFF, gw, gr);
    idle_cyc(1'b0);
    chk("raw_dvalid", 32'(rd_dvalid), 32'd1);
    chk("raw_rdata", 32'(rd_rdata), 32'h00123456);
    idle_cyc(1'b0);

    // Reset one cycle after a read accept: the read must vanish
    cycle(1'b0, 1'b0, 1'b1, '0, '0, 20'h00010, gw, gr);
    chk("rst_rd_gnt", 32'(gr), 32'd1);
    idle_cyc(1'b1);
    chk("rst_no_dvalid0", 32'(rd_dvalid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle_cyc(1'b0);
      chk("rst_no_dvalid", 32'(rd_dvalid), 32'd0);
    end
    cycle(1'b0, 1'b1, 1'b1, 20'h3, 24'h3, 20'h4, gw, gr);
    chk("rst_idle_wr_wins", 32'(gw), 32'd1);
    idle_cyc(1'b0);

    // Random traffic honouring the hold-until-grant rule
    pw = 0; pr = 0; pwa = '0; pra = '0; pwd = '0;
    for (int i = 0; i < 3000; i++) begin
      logic rst;
      rst = ($urandom_range(0, 199) == 0);
      if (!pw && $urandom_range(0, 1) == 1) begin
        pw = 1; pwa = AW'($urandom_range(0, 15)); pwd = DW'($urandom);
      end else if (pw && $urandom_range(0, 15) == 0) pw = 0;
      if (!pr && $urandom_range(0, 1) == 1) begin
        pr = 1; pra = AW'($urandom_range(0, 15));
      end else if (pr && $urandom_range(0, 15) == 0) pr = 0;
      cycle(rst, pw, pr, pwa, pwd, pra, gw, gr);
      if (rst) begin
        pw = 0; pr = 0;
      end else begin
        if (gw) pw = 0;
        if (gr) pr = 0;
      end
    end
    idle_cyc(1'b0);
    idle_cyc(1'b0);

`ifdef SRAM_ARB_STATS_EN
    idle_cyc(1'b1);
    chk("conf_reset", 32'(conflict_cnt), 32'd0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, 20'h7, 24'h7, 20'h8, gw, gr);
    chk("conf_10", 32'(conflict_cnt), 32'd10);
    idle_cyc(1'b1);
    for (int i = 0; i < 70000; i++) cycle(1'b0, 1'b1, 1'b1, 20'h7, 24'h7, 20'h8, gw, gr);
    chk("conf_sat", 32'(conflict_cnt), 32'h0000FFFF);
    idle_cyc(1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
